quad_warp_stream: RTL and testbench

Parametrised streaming quadrilateral warp engine, successor to the fixed 640x480 projective-transform stage. Consumes a raster-ordered pixel stream from the low-pass filter and maps each source pixel onto a destination quadrilateral given by four corners from object recognition. Emits (pixel, x, y) write requests to the memory interface. Uses shift-based interpolation, so no dividers are needed. A real FIFO with credit-style pixel requests guarantees no pixel is lost under memory back-pressure.

---
 rtl/quad_warp_stream_if.sv | 36 +++
 rtl/quad_warp_stream.sv | 272 +++++++++++++++++++++++++++
 tb/tb_quad_warp_stream.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_warp_stream_if.sv
// Corner, pixel-stream and write-request bundle for quad_warp_stream.
// master = system side (filter, recogniser, memory port); slave = the warp engine.
interface quad_warp_stream_if #(
  parameter int PIXEL_W = 18,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);
  logic               frame_flag;
  logic               corners_flag;
  logic [X_W-1:0]     a_x, b_x, c_x, d_x;
  logic [Y_W-1:0]     a_y, b_y, c_y, d_y;
  logic [PIXEL_W-1:0] pixel;
  logic               pixel_flag;
  logic               request_pixel;
  logic               ptflag;
  logic [PIXEL_W-1:0] pt_pixel_write;
  logic [X_W-1:0]     pt_x;
  logic [Y_W-1:0]     pt_y;
  logic               pt_wr;
  logic               busy;
  logic               overflow;

  modport master (
    output frame_flag, corners_flag,
    output a_x, b_x, c_x, d_x, a_y, b_y, c_y, d_y,
    output pixel, pixel_flag, ptflag,
    input  request_pixel, pt_pixel_write, pt_x, pt_y, pt_wr, busy, overflow
  );

  modport slave (
    input  frame_flag, corners_flag,
    input  a_x, b_x, c_x, d_x, a_y, b_y, c_y, d_y,
    input  pixel, pixel_flag, ptflag,
    output request_pixel, pt_pixel_write, pt_x, pt_y, pt_wr, busy, overflow
  );
endinterface

// File: rtl/quad_warp_stream.sv
// Streaming quadrilateral warp: raster pixels in, (pixel, x, y) writes out via shift-based
// edge/row interpolation. Define QUAD_WARP_CLIP_EN to suppress writes outside DST_W x DST_H.
module quad_warp_stream #(
  parameter int PIXEL_W    = 18,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int LOG2_W     = 9,
  parameter int LOG2_H     = 9,
  parameter int FRAC_W     = 16,
  parameter int LOG2_DEPTH = 4,
  parameter int REQ_MARGIN = 4,
  parameter int DST_W      = 640,
  parameter int DST_H      = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  quad_warp_stream_if.slave bus
);

  // One iterator width serves both axes, so y must not be wider than x.
  localparam int IW    = X_W + FRAC_W + 2;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;

  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         MARGIN_C = CW'(REQ_MARGIN);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);
  localparam logic [LOG2_W-1:0]     COL_ONE  = LOG2_W'(1);
  localparam logic [LOG2_H-1:0]     ROW_ONE  = LOG2_H'(1);

  if ((DST_W < 1) || (DST_H < 1) || (Y_W > X_W)) begin : g_bad_cfg
    $error("quad_warp_stream: DST_W/DST_H must be positive and Y_W must not exceed X_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ROW_START, S_RUN} state_t;

  state_t state_q, state_d;

  // Index 0 is the x axis, index 1 the y axis.
  logic signed [IW-1:0] a_q [2], a_d [2], b_q [2], b_d [2];
  logic signed [IW-1:0] c_q [2], c_d [2], d_q [2], d_d [2];
  logic signed [IW-1:0] l_q [2], l_d [2], r_q [2], r_d [2];
  logic signed [IW-1:0] dl_q [2], dl_d [2], dr_q [2], dr_d [2];
  logic signed [IW-1:0] p_q [2], p_d [2], dp_q [2], dp_d [2];
  logic signed [IW-1:0] a_in [2], b_in [2], c_in [2], d_in [2];
  logic signed [IW-1:0] dl_step [2], dr_step [2], dp_step [2];

  logic [LOG2_H-1:0]     row_q, row_d;
  logic [LOG2_W-1:0]     col_q, col_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [PIXEL_W-1:0]    pt_pixel_write_q, pt_pixel_write_d;
  logic [X_W-1:0]        pt_x_q, pt_x_d;
  logic [Y_W-1:0]        pt_y_q, pt_y_d;
  logic                  pt_wr_q, pt_wr_d;

  logic [PIXEL_W-1:0]    fifo_mem [DEPTH];

  logic                  active, fifo_empty, fifo_full;
  logic                  push, pop, clip_hit;
  logic [X_W-1:0]        x_new;
  logic [Y_W-1:0]        y_new;

  assign a_in[0] = IW'(bus.a_x);
  assign b_in[0] = IW'(bus.b_x);
  assign c_in[0] = IW'(bus.c_x);
  assign d_in[0] = IW'(bus.d_x);
  assign a_in[1] = IW'(bus.a_y);
  assign b_in[1] = IW'(bus.b_y);
  assign c_in[1] = IW'(bus.c_y);
  assign d_in[1] = IW'(bus.d_y);

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic signed [IW-1:0] left_span, right_span, row_span;
    assign left_span   = (d_q[gi] - a_q[gi]) <<< FRAC_W;
    assign right_span  = (c_q[gi] - b_q[gi]) <<< FRAC_W;
    assign row_span    = r_q[gi] - l_q[gi];
    assign dl_step[gi] = left_span >>> LOG2_H;
    assign dr_step[gi] = right_span >>> LOG2_H;
    assign dp_step[gi] = row_span >>> LOG2_W;
  end

  assign x_new = p_q[0][FRAC_W +: X_W];
  assign y_new = p_q[1][FRAC_W +: Y_W];

`ifdef QUAD_WARP_CLIP_EN
  localparam logic [X_W:0] DST_W_C = (X_W+1)'(DST_W);
  localparam logic [Y_W:0] DST_H_C = (Y_W+1)'(DST_H);
  assign clip_hit = ({1'b0, x_new} >= DST_W_C) || ({1'b0, y_new} >= DST_H_C);
`else
  assign clip_hit = 1'b0;
`endif

  assign active     = (state_q != S_IDLE);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  always_comb begin
    state_d          = state_q;
    a_d              = a_q;
    b_d              = b_q;
    c_d              = c_q;
    d_d              = d_q;
    l_d              = l_q;
    r_d              = r_q;
    dl_d             = dl_q;
    dr_d             = dr_q;
    p_d              = p_q;
    dp_d             = dp_q;
    row_d            = row_q;
    col_d            = col_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    overflow_d       = overflow_q;
    pt_pixel_write_d = pt_pixel_write_q;
    pt_x_d           = pt_x_q;
    pt_y_d           = pt_y_q;
    pt_wr_d          = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;

    if (active && bus.frame_flag) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.corners_flag) begin
            a_d        = a_in;
            b_d        = b_in;
            c_d        = c_in;
            d_d        = d_in;
            for (int i = 0; i < 2; i++) begin
              l_d[i] = a_in[i] <<< FRAC_W;
              r_d[i] = b_in[i] <<< FRAC_W;
            end
            row_d      = '0;
            col_d      = '0;
            overflow_d = 1'b0;
            state_d    = S_SETUP;
          end
        end
        S_SETUP: begin
          dl_d    = dl_step;
          dr_d    = dr_step;
          state_d = S_ROW_START;
        end
        S_ROW_START: begin
          dp_d    = dp_step;
          p_d     = l_q;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (!fifo_empty && bus.ptflag) begin
            pop              = 1'b1;
            pt_pixel_write_d = fifo_mem[rd_ptr_q];
            pt_x_d           = x_new;
            pt_y_d           = y_new;
            pt_wr_d          = !clip_hit;
            for (int i = 0; i < 2; i++) begin
              p_d[i] = p_q[i] + dp_q[i];
            end
            col_d = col_q + COL_ONE;
            if (&col_q) begin
              col_d = '0;
              for (int i = 0; i < 2; i++) begin
                l_d[i] = l_q[i] + dl_q[i];
                r_d[i] = r_q[i] + dr_q[i];
              end
              if (&row_q) begin
                state_d = S_IDLE;
              end else begin
                row_d   = row_q + ROW_ONE;
                state_d = S_ROW_START;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      if (active && bus.pixel_flag) begin
        if (!fifo_full || pop) begin
          push = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Any entry into IDLE (abort or end of frame) discards whatever is still queued.
    if (state_d == S_IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      for (int i = 0; i < 2; i++) begin
        a_q[i]  <= '0;
        b_q[i]  <= '0;
        c_q[i]  <= '0;
        d_q[i]  <= '0;
        l_q[i]  <= '0;
        r_q[i]  <= '0;
        dl_q[i] <= '0;
        dr_q[i] <= '0;
        p_q[i]  <= '0;
        dp_q[i] <= '0;
      end
      row_q            <= '0;
      col_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      overflow_q       <= 1'b0;
      pt_pixel_write_q <= '0;
      pt_x_q           <= '0;
      pt_y_q           <= '0;
      pt_wr_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      a_q              <= a_d;
      b_q              <= b_d;
      c_q              <= c_d;
      d_q              <= d_d;
      l_q              <= l_d;
      r_q              <= r_d;
      dl_q             <= dl_d;
      dr_q             <= dr_d;
      p_q              <= p_d;
      dp_q             <= dp_d;
      row_q            <= row_d;
      col_q            <= col_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      overflow_q       <= overflow_d;
      pt_pixel_write_q <= pt_pixel_write_d;
      pt_x_q           <= pt_x_d;
      pt_y_q           <= pt_y_d;
      pt_wr_q          <= pt_wr_d;
    end
  end

  assign bus.request_pixel  = active && ((DEPTH_C - count_q) > MARGIN_C);
  assign bus.busy           = active;
  assign bus.overflow       = overflow_q;
  assign bus.pt_pixel_write = pt_pixel_write_q;
  assign bus.pt_x           = pt_x_q;
  assign bus.pt_y           = pt_y_q;
  assign bus.pt_wr          = pt_wr_q;

endmodule

// File: tb/tb_quad_warp_stream.sv
// Directed bench for quad_warp_stream on a 4x4 source frame (FRAC_W=8, depth 16, DST_W=16).
// Write requests are collected at the falling edge and compared against hand-derived maps.
module tb_quad_warp_stream;

  localparam int PIXEL_W = 18;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
`ifdef QUAD_WARP_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quad_warp_stream_if #(.PIXEL_W(PIXEL_W), .X_W(X_W), .Y_W(Y_W)) bus ();

  quad_warp_stream #(
    .PIXEL_W(PIXEL_W), .X_W(X_W), .Y_W(Y_W),
    .LOG2_W(2), .LOG2_H(2), .FRAC_W(8),
    .LOG2_DEPTH(4), .REQ_MARGIN(4),
    .DST_W(16), .DST_H(480)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got_pix [$];
  logic [31:0] got_x   [$];
  logic [31:0] got_y   [$];
  logic [31:0] exp_pix [$];
  logic [31:0] exp_x   [$];
  logic [31:0] exp_y   [$];

  always @(negedge clk) begin
    if (rst_n && bus.pt_wr === 1'b1) begin
      got_pix.push_back(32'(bus.pt_pixel_write));
      got_x.push_back(32'(bus.pt_x));
      got_y.push_back(32'(bus.pt_y));
      $display("wr  pixel=%0d x=%0d y=%0d", bus.pt_pixel_write, bus.pt_x, bus.pt_y);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    got_pix.delete(); got_x.delete(); got_y.delete();
    exp_pix.delete(); exp_x.delete(); exp_y.delete();
  endtask

  task automatic start_frame(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, input int dx, input int dy,
                             input bit ff);
    bus.a_x = ax[X_W-1:0]; bus.a_y = ay[Y_W-1:0];
    bus.b_x = bx[X_W-1:0]; bus.b_y = by[Y_W-1:0];
    bus.c_x = cx[X_W-1:0]; bus.c_y = cy[Y_W-1:0];
    bus.d_x = dx[X_W-1:0]; bus.d_y = dy[Y_W-1:0];
    bus.corners_flag = 1'b1;
    bus.frame_flag   = ff;
    tick();
    bus.corners_flag = 1'b0;
    bus.frame_flag   = 1'b0;
  endtask

  // Push n pixels base..base+n-1, waiting for request_pixel before each one.
  task automatic stream(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      while (!bus.request_pixel && guard < 100) begin
        tick();
        guard++;
      end
      if (guard == 100) check("stream_request", 32'(bus.request_pixel), 32'd1);
      bus.pixel      = PIXEL_W'(base + k);
      bus.pixel_flag = 1'b1;
      tick();
    end
    bus.pixel_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && bus.busy; i++) tick();
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    tick();
  endtask

  // Affine 4x4 map: pixel k lands at (x0 + sx*(k%4), y0 + sy*(k/4)).
  task automatic expect_map(input int base, input int x0, input int y0, input int sx, input int sy);
    for (int k = 0; k < 16; k++) begin
      int ex, ey;
      ex = x0 + sx * (k % 4);
      ey = y0 + sy * (k / 4);
      if (!(CLIP_ON && (ex >= 16 || ey >= 480))) begin
        exp_pix.push_back(32'(base + k));
        exp_x.push_back(32'(ex));
        exp_y.push_back(32'(ey));
      end
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, 32'(got_pix.size()), 32'(exp_pix.size()));
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      check($sformatf("%s_pix%0d", tag, i), got_pix[i], exp_pix[i]);
      check($sformatf("%s_x%0d", tag, i), got_x[i], exp_x[i]);
      check($sformatf("%s_y%0d", tag, i), got_y[i], exp_y[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    bus.frame_flag = 1'b0; bus.corners_flag = 1'b0;
    bus.a_x = '0; bus.b_x = '0; bus.c_x = '0; bus.d_x = '0;
    bus.a_y = '0; bus.b_y = '0; bus.c_y = '0; bus.d_y = '0;
    bus.pixel = '0; bus.pixel_flag = 1'b0; bus.ptflag = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_request", 32'(bus.request_pixel), 32'd0);
    check("rst_pt_wr", 32'(bus.pt_wr), 32'd0);
    check("rst_pt_pixel", 32'(bus.pt_pixel_write), 32'd0);
    check("rst_pt_x", 32'(bus.pt_x), 32'd0);
    check("rst_pt_y", 32'(bus.pt_y), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    // Identity mapping.
    clear_queues();
    bus.ptflag = 1'b1;
    start_frame(0, 0, 4, 0, 4, 4, 0, 4, 1'b0);
    check("ident_busy_t1", 32'(bus.busy), 32'd1);
    check("ident_req_t1", 32'(bus.request_pixel), 32'd1);
    stream(0, 16);
    wait_idle("ident");
    expect_map(0, 0, 0, 1, 1);
    verify("ident");

    // 2x scale with offset.
    clear_queues();
    start_frame(10, 20, 18, 20, 18, 28, 10, 28, 1'b0);
    stream(100, 16);
    wait_idle("scale");
    expect_map(100, 10, 20, 2, 2);
    verify("scale");

    // Back-pressure: request_pixel drops with 12 queued, margin of 4 still fits.
    clear_queues();
    bus.ptflag = 1'b0;
    start_frame(0, 0, 4, 0, 4, 4, 0, 4, 1'b0);
    pushed = 0;
    for (int c = 0; c < 40 && bus.request_pixel; c++) begin
      bus.pixel      = PIXEL_W'(200 + pushed);
      bus.pixel_flag = 1'b1;
      tick();
      pushed++;
    end
    bus.pixel_flag = 1'b0;
    check("bp_queued", 32'(pushed), 32'd12);
    check("bp_req_low", 32'(bus.request_pixel), 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus.pixel      = PIXEL_W'(200 + pushed);
      bus.pixel_flag = 1'b1;
      tick();
      pushed++;
    end
    bus.pixel_flag = 1'b0;
    check("bp_overflow", 32'(bus.overflow), 32'd0);
    check("bp_no_wr_while_stalled", 32'(got_pix.size()), 32'd0);
    bus.ptflag = 1'b1;
    wait_idle("bp");
    expect_map(200, 0, 0, 1, 1);
    verify("bp");

    // Overflow: 17th pixel into a full FIFO is dropped.
    clear_queues();
    bus.ptflag = 1'b0;
    start_frame(0, 0, 4, 0, 4, 4, 0, 4, 1'b0);
    for (int k = 0; k < 17; k++) begin
      bus.pixel      = PIXEL_W'(300 + k);
      bus.pixel_flag = 1'b1;
      tick();
    end
    bus.pixel_flag = 1'b0;
    check("ovf_set", 32'(bus.overflow), 32'd1);
    bus.ptflag = 1'b1;
    wait_idle("ovf");
    expect_map(300, 0, 0, 1, 1);
    verify("ovf");
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Abort mid-row 2, then restart from row 0 with nothing stale left over.
    clear_queues();
    start_frame(0, 0, 4, 0, 4, 4, 0, 4, 1'b0);
    check("abort_ovf_cleared", 32'(bus.overflow), 32'd0);
    stream(400, 10);
    for (int i = 0; i < 100 && got_pix.size() < 9; i++) tick();
    check("abort_reached_row2", 32'(got_pix.size() >= 9), 32'd1);
    bus.frame_flag = 1'b1;
    tick();
    bus.frame_flag = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_pt_wr", 32'(bus.pt_wr), 32'd0);
    check("abort_request", 32'(bus.request_pixel), 32'd0);
    clear_queues();
    repeat (3) tick();
    check("abort_silent", 32'(got_pix.size()), 32'd0);
    start_frame(0, 0, 4, 0, 4, 4, 0, 4, 1'b0);
    stream(500, 16);
    wait_idle("restart");
    expect_map(500, 0, 0, 1, 1);
    verify("restart");

    // Clipping window; frame_flag in IDLE alongside corners must not block acceptance.
    clear_queues();
    start_frame(12, 0, 20, 0, 20, 4, 12, 4, 1'b1);
    check("clip_accept_busy", 32'(bus.busy), 32'd1);
    stream(600, 16);
    wait_idle("clip");
    expect_map(600, 12, 0, 2, 1);
    verify("clip");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
